ahb_fetch_unit: RTL

Parametrised instruction-fetch front end for the RV core. It requests the AHB bus, issues single word reads at a sequential program counter and buffers returned instructions with their PCs in a prefetch FIFO. It supports redirect (branch/jump/trap) with flush and discard of in-flight data. It sits between the AHB master port and the decoder stage, and replaces the core's ad-hoc fetch logic.

---
 rtl/ahb_fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ahb_fetch_unit.sv
// Instruction-fetch front end: single-word AHB reads into a prefetch FIFO.
// Redirect flushes the FIFO and drops any data phase already in flight.
module ahb_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              nRst,
    output logic              HBUSREQ,
    input  logic              HGRANT,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HRDATA,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);
    localparam int OFF = $clog2(DATA_W / 8);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(DATA_W / 8);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_REQ, S_ADDR, S_DATA} state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] data_pc_q, data_pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic pend_q, pend_d;
    logic discard_q, discard_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q [DEPTH];
    logic room, req, push, pop;
    logic [ADDR_W-1:0] redir_pc;

    assign redir_pc = {redirect_pc[ADDR_W-1:OFF], {OFF{1'b0}}};
    assign room = count_q < FULL;

    assign HADDR = fetch_pc_q;
    assign HTRANS = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    assign HBUSREQ = nRst & req;

    assign inst_valid = count_q != '0;
    assign inst_data = inst_valid ? data_mem_q[rd_ptr_q] : '0;
    assign inst_pc = inst_valid ? pc_mem_q[rd_ptr_q] : '0;

    assign push = (state_q == S_DATA) & HREADY & ~discard_q & ~redirect;
    assign pop = inst_valid & inst_ready & ~redirect;

    always_comb begin
        state_d = state_q;
        fetch_pc_d = fetch_pc_q;
        data_pc_d = data_pc_q;
        pend_d = pend_q;
        pend_pc_d = pend_pc_q;
        discard_d = discard_q;
        req = 1'b0;
        unique case (state_q)
            S_REQ: begin
                req = room;
                if (room && HGRANT) state_d = S_ADDR;
                if (redirect) fetch_pc_d = redir_pc;
            end
            S_ADDR: begin
                req = 1'b1;
                if (HREADY) begin
                    data_pc_d = fetch_pc_q;
                    fetch_pc_d = pend_q ? pend_pc_q : fetch_pc_q + INC;
                    pend_d = 1'b0;
                    state_d = S_DATA;
                    if (redirect) begin
                        fetch_pc_d = redir_pc;
                        discard_d = 1'b1;
                    end
                end else if (redirect) begin
                    // HADDR must hold while stalled; apply the new PC later
                    pend_d = 1'b1;
                    pend_pc_d = redir_pc;
                    discard_d = 1'b1;
                end
            end
            S_DATA: begin
                if (redirect) fetch_pc_d = redir_pc;
                if (HREADY) begin
                    discard_d = 1'b0;
                    state_d = S_REQ;
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_REQ;
            fetch_pc_q <= RESET_PC;
            data_pc_q <= '0;
            pend_q <= 1'b0;
            pend_pc_q <= '0;
            discard_q <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            data_pc_q <= data_pc_d;
            pend_q <= pend_d;
            pend_pc_q <= pend_pc_d;
            discard_q <= discard_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= HRDATA;
            pc_mem_q[wr_ptr_q] <= data_pc_q;
        end
    end
endmodule
